jtag_tap_mdr: RTL and testbench
===============================

JTAG_TAP_MDR -- requirements
Module: jtag_tap_mdr

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register width (minimum 2).
REQ-002 SHALL have parameter NUM_CH, default 4, number of user debug DR channels (1..8).
REQ-003 SHALL have parameter DR_WIDTH, default 32, user/IDCODE DR length (8..64).
REQ-004 SHALL have parameter IDCODE_VAL, default 32'h0BA00477, value captured for IDCODE.
REQ-005 SHALL have parameter CH_IR_BASE, default 5'h10, opcode of channel 0; channel k opcode = CH_IR_BASE+k.
REQ-006 SHALL have port clk_i  input  1  system clock, at least 4x TCK frequency.
REQ-007 SHALL have port trst_sync  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports tck_i, tms_i, tdi_i  input  1 each  raw JTAG pins, asynchronous to clk_i.
REQ-009 SHALL have port tdo_o  output  1  serial data out; tdo_oe_o  output  1  TDO drive enable.
REQ-010 SHALL have port tap_state_o  output  4  current TAP state (IEEE 1149.1 encoding 0..15: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR).
REQ-011 SHALL have port ir_o  output  IR_WIDTH  active instruction; ir_upd_o  output  1  one-cycle pulse on instruction update.
REQ-012 SHALL have port ch_sel_o  output  NUM_CH  one-hot active channel (all zero if none).
REQ-013 SHALL have port ch_cap_data_i  input  NUM_CH*DR_WIDTH  capture data, channel k at bits [k*DR_WIDTH +: DR_WIDTH].
REQ-014 SHALL have port ch_cap_o  output  NUM_CH  one-cycle capture strobe per channel.
REQ-015 SHALL have ports ch_upd_data_o  output  DR_WIDTH  shifted-in value; ch_upd_o  output  NUM_CH  one-cycle update strobe per channel.

Function
REQ-016 SHALL synchronise tck_i, tms_i, tdi_i with 2-flop synchronisers on clk_i; tck_rise/tck_fall = single-cycle edge detects of synchronised TCK.
REQ-017 SHALL advance TAP state only on tck_rise per IEEE 1149.1 16-state graph using synchronised TMS; no state change otherwise.
REQ-018 SHALL reach TLR from any state after 5 consecutive tck_rise with TMS=1.
REQ-019 SHALL, on tck_rise in CAP_IR, load IR shift register with {'0, 2'b01}; in SH_IR shift right with TDI into MSB.
REQ-020 SHALL, on tck_fall in UPD_IR, copy IR shift register to ir_o and pulse ir_upd_o for one clk_i cycle.
REQ-021 SHALL force ir_o to IDCODE (1) while in TLR.
REQ-022 SHALL decode: all-ones = BYPASS; 1 = IDCODE; CH_IR_BASE..CH_IR_BASE+NUM_CH-1 = channel; any other opcode = BYPASS.
REQ-023 SHALL, on tck_rise in CAP_DR: IDCODE loads IDCODE_VAL zero-extended/truncated to DR_WIDTH; channel k loads its ch_cap_data_i slice and pulses ch_cap_o[k]; BYPASS loads bypass bit 0.
REQ-024 SHALL, on tck_rise in SH_DR, shift selected register right with TDI into MSB (bypass: 1-bit register).
REQ-025 SHALL update TDO on tck_fall only: SH_DR -> selected register LSB, SH_IR -> IR shift LSB; tdo_oe_o=1 only during SH_DR/SH_IR; tdo_o=0 when disabled.
REQ-026 SHALL, on tck_fall in UPD_DR with channel k selected, drive ch_upd_data_o with DR shift register and pulse ch_upd_o[k] one clk_i cycle; ch_upd_data_o holds until next update.
REQ-027 SHALL keep shift registers unchanged in PA_DR/PA_IR/EX1/EX2 states (resumable shift).
REQ-028 SHALL never assert more than one bit of ch_sel_o, ch_cap_o, ch_upd_o.
REQ-029 SHALL hold all outputs stable when TCK stops; no pulses without a TCK edge.

Reset
REQ-030 SHALL, on trst_sync low, asynchronously set state=TLR, ir_o=1, all shift registers 0, tdo_o=0, tdo_oe_o=0, ch_sel_o=0, all strobes 0, ch_upd_data_o=0, synchroniser flops 0.
REQ-031 SHALL, on reset asserted mid-shift, abandon the scan with no ch_upd_o pulse; first tck_rise after release evaluated from TLR.

Verification
REQ-032 Reset, 5 TMS=1 clocks, then TMS=0 -> TLR held, RTI reached, ir_o=1, tdo_oe_o=0.
REQ-033 IDCODE scan: RTI->SH_DR, 32 bits out -> TDO LSB-first reads 0x0BA00477; ch_upd_o stays 0.
REQ-034 IR scan 5'h12 then DR scan 0xDEADBEEF with ch_cap_data_i slice2=0x12345678 -> ch_cap_o[2] pulse, TDO 0x12345678, ch_upd_o[2] one pulse, ch_upd_data_o=0xDEADBEEF.
REQ-035 IR scan all-ones, 8-bit DR shift of 0xA5 -> TDO returns 0 then 0xA5 delayed one bit; no channel strobe.
REQ-036 Channel 1 DR scan paused 10 TCK in PA_DR mid-shift, resumed -> final ch_upd_data_o identical to unpaused scan.
REQ-037 trst_sync low after 16 shifted bits of channel 0 -> state TLR, ir_o=1, no ch_upd_o pulse, ch_upd_data_o=0.

Source files
------------

// File: rtl/jtag_tap_mdr.sv
// JTAG TAP controller with IR, IDCODE, bypass and NUM_CH user debug data
// registers. All JTAG pins are oversampled on clk_i; TAP actions happen on
// detected TCK rising/falling edges.
module jtag_tap_mdr #(
  parameter int unsigned         IR_WIDTH   = 5,
  parameter int unsigned         NUM_CH     = 4,
  parameter int unsigned         DR_WIDTH   = 32,
  parameter logic [31:0]         IDCODE_VAL = 32'h0BA00477,
  parameter logic [IR_WIDTH-1:0] CH_IR_BASE = IR_WIDTH'(5'h10)
) (
  input  logic                         clk_i,
  input  logic                         trst_sync,
  input  logic                         tck_i,
  input  logic                         tms_i,
  input  logic                         tdi_i,
  output logic                         tdo_o,
  output logic                         tdo_oe_o,
  output logic [3:0]                   tap_state_o,
  output logic [IR_WIDTH-1:0]          ir_o,
  output logic                         ir_upd_o,
  output logic [NUM_CH-1:0]            ch_sel_o,
  input  logic [NUM_CH*DR_WIDTH-1:0]   ch_cap_data_i,
  output logic [NUM_CH-1:0]            ch_cap_o,
  output logic [DR_WIDTH-1:0]          ch_upd_data_o,
  output logic [NUM_CH-1:0]            ch_upd_o
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  logic tck_meta, tck_sync, tck_prev;
  logic tms_meta, tms_sync;
  logic tdi_meta, tdi_sync;
  logic tck_rise, tck_fall;

  tap_state_t            state, next_state;
  logic [IR_WIDTH-1:0]   ir, ir_sr;
  logic [DR_WIDTH-1:0]   dr_sr, upd_data, cap_mux;
  logic                  byp;
  logic                  sel_idcode, sel_bypass;
  logic [NUM_CH-1:0]     sel_ch, cap_stb, upd_stb;
  logic                  ir_upd, tdo, tdo_oe;

  // Two-flop synchronisers plus a history flop for TCK edge detection
  always_ff @(posedge clk_i or negedge trst_sync) begin
    if (!trst_sync) begin
      tck_meta <= 1'b0; tck_sync <= 1'b0; tck_prev <= 1'b0;
      tms_meta <= 1'b0; tms_sync <= 1'b0;
      tdi_meta <= 1'b0; tdi_sync <= 1'b0;
    end else begin
      tck_meta <= tck_i;  tck_sync <= tck_meta; tck_prev <= tck_sync;
      tms_meta <= tms_i;  tms_sync <= tms_meta;
      tdi_meta <= tdi_i;  tdi_sync <= tdi_meta;
    end
  end

  assign tck_rise = tck_sync & ~tck_prev;
  assign tck_fall = ~tck_sync & tck_prev;

  // Instruction decode; first matching channel wins so selection stays one-hot
  always_comb begin
    sel_idcode = 1'b0;
    sel_ch     = '0;
    cap_mux    = '0;
    if (ir != '1) begin
      if (ir == IR_WIDTH'(1)) begin
        sel_idcode = 1'b1;
      end else begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (sel_ch == '0 && ir == CH_IR_BASE + IR_WIDTH'(k)) sel_ch[k] = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel_ch[k]) cap_mux = ch_cap_data_i[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  assign sel_bypass = ~sel_idcode & (sel_ch == '0);

  // IEEE 1149.1 state graph
  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms_sync ? TLR    : RTI;
      RTI:    next_state = tms_sync ? SEL_DR : RTI;
      SEL_DR: next_state = tms_sync ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms_sync ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms_sync ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms_sync ? UPD_DR : PA_DR;
      PA_DR:  next_state = tms_sync ? EX2_DR : PA_DR;
      EX2_DR: next_state = tms_sync ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms_sync ? SEL_DR : RTI;
      SEL_IR: next_state = tms_sync ? TLR    : CAP_IR;
      CAP_IR: next_state = tms_sync ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms_sync ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms_sync ? UPD_IR : PA_IR;
      PA_IR:  next_state = tms_sync ? EX2_IR : PA_IR;
      EX2_IR: next_state = tms_sync ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms_sync ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // TAP state, shift registers, TDO and strobes; capture/shift on TCK rise,
  // update/TDO on TCK fall
  always_ff @(posedge clk_i or negedge trst_sync) begin
    if (!trst_sync) begin
      state    <= TLR;
      ir       <= IR_WIDTH'(1);
      ir_sr    <= '0;
      dr_sr    <= '0;
      byp      <= 1'b0;
      upd_data <= '0;
      tdo      <= 1'b0;
      tdo_oe   <= 1'b0;
      ir_upd   <= 1'b0;
      cap_stb  <= '0;
      upd_stb  <= '0;
    end else begin
      ir_upd  <= 1'b0;
      cap_stb <= '0;
      upd_stb <= '0;
      if (tck_rise) begin
        state <= next_state;
        case (state)
          CAP_IR: ir_sr <= IR_WIDTH'(2'b01);
          SH_IR:  ir_sr <= {tdi_sync, ir_sr[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_bypass) begin
              byp <= 1'b0;
            end else begin
              dr_sr   <= sel_idcode ? DR_WIDTH'(IDCODE_VAL) : cap_mux;
              cap_stb <= sel_ch;
            end
          end
          SH_DR: begin
            if (sel_bypass) byp <= tdi_sync;
            else            dr_sr <= {tdi_sync, dr_sr[DR_WIDTH-1:1]};
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        tdo_oe <= (state == SH_DR) || (state == SH_IR);
        case (state)
          SH_DR:   tdo <= sel_bypass ? byp : dr_sr[0];
          SH_IR:   tdo <= ir_sr[0];
          default: tdo <= 1'b0;
        endcase
        if (state == UPD_IR) begin
          ir     <= ir_sr;
          ir_upd <= 1'b1;
        end
        if (state == UPD_DR && sel_ch != '0) begin
          upd_data <= dr_sr;
          upd_stb  <= sel_ch;
        end
      end
      // TLR always holds IDCODE as the active instruction
      if (state == TLR) ir <= IR_WIDTH'(1);
    end
  end

  assign tdo_o         = tdo;
  assign tdo_oe_o      = tdo_oe;
  assign tap_state_o   = state;
  assign ir_o          = ir;
  assign ir_upd_o      = ir_upd;
  assign ch_sel_o      = sel_ch;
  assign ch_cap_o      = cap_stb;
  assign ch_upd_o      = upd_stb;
  assign ch_upd_data_o = upd_data;

endmodule

// File: tb/tb_jtag_tap_mdr.sv
// Scoreboard bench for jtag_tap_mdr: stimulus queues expected events,
// a clk-driven monitor pops and compares when the DUT presents them.
module tb_jtag_tap_mdr;

  localparam int K_PROBE = 0, K_CAP = 1, K_TDO = 2, K_IR = 3, K_UPD = 4;

  typedef struct {
    int          kind;
    logic [63:0] val;
    int          cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         trst_sync;
  logic         tck_i, tms_i, tdi_i;
  logic         tdo_o, tdo_oe_o, ir_upd_o;
  logic [3:0]   tap_state_o;
  logic [4:0]   ir_o;
  logic [3:0]   ch_sel_o, ch_cap_o, ch_upd_o;
  logic [127:0] ch_cap_data_i;
  logic [31:0]  ch_upd_data_o;

  exp_t q[$];
  int   compared = 0, mismatched = 0;
  int   probe_cnt = 0, probe_seen = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  jtag_tap_mdr #(
    .IR_WIDTH(5), .NUM_CH(4), .DR_WIDTH(32),
    .IDCODE_VAL(32'h0BA00477), .CH_IR_BASE(5'h10)
  ) dut (
    .clk_i(clk), .trst_sync(trst_sync),
    .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .tap_state_o(tap_state_o),
    .ir_o(ir_o), .ir_upd_o(ir_upd_o), .ch_sel_o(ch_sel_o),
    .ch_cap_data_i(ch_cap_data_i), .ch_cap_o(ch_cap_o),
    .ch_upd_data_o(ch_upd_data_o), .ch_upd_o(ch_upd_o)
  );

  function automatic logic [63:0] pack_probe(input logic [3:0] st, input logic [4:0] ir,
                                             input logic oe, input logic td,
                                             input logic [3:0] sel, input logic [31:0] d);
    return {17'b0, d, sel, td, oe, st, ir};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_PROBE: return "probe";
      K_CAP:   return "cap_strobe";
      K_TDO:   return "tdo_scan";
      K_IR:    return "ir_update";
      K_UPD:   return "ch_update";
      default: return "none";
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        tck_prev = 1'b0, oe_prev = 1'b0;
  logic [63:0] acc = '0;
  int          nbits = 0;

  task automatic check(input int kind, input logic [63:0] val, input int cnt);
    exp_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: got %h/%0d, required no event", kname(kind), val, cnt);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== val || e.cnt != cnt) begin
        mismatched++;
        $display("FAIL %s: got %s %h/%0d, required %s %h/%0d",
                 kname(kind), kname(kind), val, cnt, kname(e.kind), e.val, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tck_i && !tck_prev && tdo_oe_o && nbits < 64) begin
      acc[nbits] = tdo_o;
      nbits++;
    end
    tck_prev = tck_i;
    if (probe_cnt != probe_seen) begin
      probe_seen++;
      check(K_PROBE, pack_probe(tap_state_o, ir_o, tdo_oe_o, tdo_o, ch_sel_o, ch_upd_data_o), 0);
    end
    if (ch_cap_o != '0) check(K_CAP, {60'b0, ch_cap_o}, 0);
    if (ir_upd_o)       check(K_IR, {59'b0, ir_o}, 0);
    if (ch_upd_o != '0) check(K_UPD, {28'b0, ch_upd_o, ch_upd_data_o}, 0);
    if (oe_prev && !tdo_oe_o) begin
      check(K_TDO, acc, nbits);
      acc   = '0;
      nbits = 0;
    end
    oe_prev = tdo_oe_o;
    if (done) begin
      compared++;
      if (q.size() != 0) begin
        mismatched++;
        $display("FAIL missing_events: got %0d pending, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic push(input int kind, input logic [63:0] val, input int cnt);
    exp_t e;
    e.kind = kind; e.val = val; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic probe(input logic [3:0] st, input logic [4:0] ir,
                       input logic [3:0] sel, input logic [31:0] d);
    #60;
    push(K_PROBE, pack_probe(st, ir, 1'b0, 1'b0, sel, d), 0);
    probe_cnt++;
    #20;
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi);
    tms_i = tms;
    tdi_i = tdi;
    #40 tck_i = 1'b1;
    #40 tck_i = 1'b0;
  endtask

  task automatic ir_scan(input logic [4:0] v);
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] v);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  task automatic dr_scan_paused(input logic [31:0] v);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 12; i++) tck_cycle(i == 11, v[i]);
    tck_cycle(0, 0);
    repeat (10) tck_cycle(0, 1);
    tck_cycle(1, 0); tck_cycle(0, 0);
    for (int i = 12; i < 32; i++) tck_cycle(i == 31, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  initial begin
    trst_sync = 1'b0; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0;
    ch_cap_data_i = {32'h55AA55AA, 32'h12345678, 32'hCAFEF00D, 32'h0F1E2D3C};
    #22;
    probe(4'd0, 5'h01, 4'b0000, 32'h0);
    trst_sync = 1'b1;
    #20;

    repeat (5) tck_cycle(1, 0);
    probe(4'd0, 5'h01, 4'b0000, 32'h0);
    tck_cycle(0, 0);
    probe(4'd1, 5'h01, 4'b0000, 32'h0);

    // IDCODE read
    push(K_TDO, 64'h0BA00477, 32);
    dr_scan(32, 64'h0);
    probe(4'd1, 5'h01, 4'b0000, 32'h0);

    // channel 2 capture/update
    push(K_TDO, 64'h01, 5); push(K_IR, 64'h12, 0);
    ir_scan(5'h12);
    probe(4'd1, 5'h12, 4'b0100, 32'h0);
    push(K_CAP, 64'h4, 0); push(K_TDO, 64'h12345678, 32);
    push(K_UPD, {28'b0, 4'b0100, 32'hDEADBEEF}, 0);
    dr_scan(32, 64'hDEADBEEF);
    probe(4'd1, 5'h12, 4'b0100, 32'hDEADBEEF);

    // bypass: one-bit delay, leading zero
    push(K_TDO, 64'h01, 5); push(K_IR, 64'h1F, 0);
    ir_scan(5'h1F);
    probe(4'd1, 5'h1F, 4'b0000, 32'hDEADBEEF);
    push(K_TDO, 64'h14A, 9);
    dr_scan(9, 64'h0A5);
    probe(4'd1, 5'h1F, 4'b0000, 32'hDEADBEEF);

    // channel 1: straight scan, then the same scan paused mid-way
    push(K_TDO, 64'h01, 5); push(K_IR, 64'h11, 0);
    ir_scan(5'h11);
    probe(4'd1, 5'h11, 4'b0010, 32'hDEADBEEF);
    push(K_CAP, 64'h2, 0); push(K_TDO, 64'hCAFEF00D, 32);
    push(K_UPD, {28'b0, 4'b0010, 32'h5A5A1234}, 0);
    dr_scan(32, 64'h5A5A1234);
    push(K_CAP, 64'h2, 0); push(K_TDO, 64'h00D, 12); push(K_TDO, 64'hCAFEF, 20);
    push(K_UPD, {28'b0, 4'b0010, 32'h5A5A1234}, 0);
    dr_scan_paused(32'h5A5A1234);
    probe(4'd1, 5'h11, 4'b0010, 32'h5A5A1234);

    // channel 0: reset after 16 shifted bits
    push(K_TDO, 64'h01, 5); push(K_IR, 64'h10, 0);
    ir_scan(5'h10);
    push(K_CAP, 64'h1, 0); push(K_TDO, 64'h2D3C, 16);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 16; i++) tck_cycle(0, i[0]);
    #30 trst_sync = 1'b0;
    probe(4'd0, 5'h01, 4'b0000, 32'h0);
    trst_sync = 1'b1;
    #40;
    tck_cycle(0, 0);
    probe(4'd1, 5'h01, 4'b0000, 32'h0);

    #100;
    done = 1'b1;
  end

endmodule
